// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic-lab types and constants
// Purpose: FSM state encoding and default operand width for serial_addsub.
// Exports: state_e {IDLE, SHIFT, DONE}, DEFAULT_W.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_W = 4;

endpackage

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - 1-bit combinational full adder
// Purpose: the single adder cell shared by every bit position of serial_addsub.
// Ports:
//   a, b  in   operand bits
//   ci    in   carry in
//   s     out  sum bit
//   co    out  carry out (majority of a, b, ci)
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - bit-serial two's-complement adder/subtractor
// Purpose: computes A + B or A - B (as A + ~B + 1) one bit per clock, LSB first,
// using one full-adder cell and a carry flip-flop. Result after W shift cycles.
// Optional feature macro: SERIAL_ADDSUB_OVF_EN (signed overflow flag on ovf).
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   request, sampled in IDLE or DONE
//   sub    in   0 = add, 1 = subtract, sampled with start
//   A, B   in   W-bit signed operands, sampled with start
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse when s/cout/ovf are valid
//   s      out  registered W-bit result (modulo 2^W)
//   cout   out  carry out of MSB (subtract: 1 = no borrow)
//   ovf    out  signed overflow, constant 0 unless SERIAL_ADDSUB_OVF_EN
module serial_addsub
  import arith_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         ovf
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_e        state;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic [W-1:0]  acc;
  logic          carry;
  logic [CW-1:0] cnt;

  logic          fa_s;
  logic          fa_co;
  logic [W-1:0]  acc_next;
  logic          last_bit;

  fa_cell u_fa (
    .a  (op_a[0]),
    .b  (op_b[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Sum bits enter at the top so that after W shifts bit 0 of the result sits at acc[0].
  assign acc_next = {fa_s, acc[W-1:1]};
  assign last_bit = (state == SHIFT) && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            // Subtract is A + ~B + 1: invert B and seed the carry with 1.
            op_a  <= A;
            op_b  <= B ^ {W{sub}};
            carry <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          acc   <= acc_next;
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          carry <= fa_co;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            s     <= acc_next;
            cout  <= fa_co;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  // On the MSB cycle the carry register holds the carry into the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (last_bit) begin
      ovf <= carry ^ fa_co;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule
